gmii_rx_fcs_check: RTL and testbench
====================================

Name: gmii_rx_fcs_check

Overview:
GMII receive-side frame checker; the counterpart of the team's GMII transmit path and its CRC-32 generator.
- Detects preamble/SFD and strips them.
- Streams payload bytes out with the 4-byte FCS removed.
- Verifies the FCS by CRC-32 residue and checks frame length.
- Reports a single-cycle end-of-frame status.
- Sits between the PHY GMII RX pins (after input registering) and the MAC RX parser.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (after SFD, FCS included)
MAX_LEN, 1518, maximum legal frame length in bytes (after SFD, FCS included)
CNT_W, 32, width of statistics counters (used only with RX_STATS_EN)

Ports:
clk  in  1  receive clock (GMII RX clock domain)
rst_n  in  1  synchronous active-low reset
gmii_rxd  in  8  GMII receive data
gmii_rx_dv  in  1  GMII receive data valid
gmii_rx_er  in  1  GMII receive error
rx_data  out  8  payload byte (FCS excluded)
rx_valid  out  1  rx_data valid this cycle
rx_sof  out  1  with first payload byte
rx_eof  out  1  single-cycle frame-end status strobe; never coincident with rx_valid
rx_good  out  1  frame good; qualified by rx_eof
rx_crc_err  out  1  residue mismatch; qualified by rx_eof
rx_len_err  out  1  length outside [MIN_LEN, MAX_LEN]; qualified by rx_eof
rx_phy_err  out  1  gmii_rx_er seen during frame; qualified by rx_eof
rx_len  out  16  frame byte count after SFD, FCS included, saturating at 16'hFFFF; qualified by rx_eof

Behaviour:
Clocking and reset:
- Single clock domain.
- Reset is synchronous and active-low.
- While rst_n=0, every output is 0 and the FSM is WAIT_IDLE.
- The CRC register is all ones.
- The delay line is empty.
- The length counter is 0.

FSM states:
- WAIT_IDLE: go to IDLE when gmii_rx_dv=0. This prevents acceptance of a frame that was already in progress at reset.
- IDLE: on gmii_rx_dv=1, gmii_rxd=8'h55, gmii_rx_er=0 go to PREAMBLE. On dv=1 with any other byte go to WAIT_IDLE.
- PREAMBLE:
  - 8'h55 stays in PREAMBLE.
  - 8'hD5 goes to DATA, presets CRC to all ones, and clears the counter and error flags.
  - Any other byte, or gmii_rx_er=1, goes to WAIT_IDLE.
  - dv=0 goes to IDLE.
  - No outputs are generated for aborted preambles.
- DATA:
  - Each byte with dv=1 is folded into the CRC and the length counter increments.
  - The byte is pushed into a 4-byte delay line.
  - gmii_rx_er=1 sets a sticky phy_err flag; the state stays DATA.
  - dv=0 ends the frame and the FSM goes to IDLE.

CRC:
- CRC-32 polynomial 0x04C11DB7, 8 bits per clock, register preset to all ones.
- The engine input bit i equals gmii_rxd[7-i].
- The frame passes when the register equals residue 32'hC704DD7B after the final FCS byte.

Output latency:
- Payload byte N (0-based after SFD) appears on rx_data/rx_valid in the cycle after the edge that samples byte N+4.
- The 4 FCS bytes therefore remain in the delay line and are never emitted.
- rx_sof is asserted with byte 0.
- Frames of 4 bytes or fewer emit no rx_valid.

End of frame:
- rx_eof is asserted in the cycle after the edge that samples dv=0 in DATA.
- rx_crc_err = (CRC != residue).
- rx_len_err = (rx_len < MIN_LEN) or (rx_len > MAX_LEN).
- rx_good = none of the three error flags set.
- The delay line is flushed.
- Status outputs are 0 whenever rx_eof=0.

Boundary conditions:
- The length counter saturates at 16'hFFFF and never wraps.
- Back-to-back frames: a single dv=0 cycle between frames suffices. eof for frame k and the first preamble byte of frame k+1 are handled in adjacent cycles.
- Reset mid-frame: a frame in progress produces no eof, and the block waits for dv=0 before accepting a new frame.

Optional Feature:
RX_STATS_EN
- Defined: adds outputs stat_good_cnt, stat_crc_cnt, stat_len_cnt, stat_phy_cnt (each CNT_W). Each increments on rx_eof when the corresponding status bit is set; a frame may count in several error counters. Counters saturate at all ones, reset to 0 with rst_n, and add input stat_clr, which synchronously zeroes all counters; stat_clr has priority over increment.
- Undefined: these ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package gmii_pkg holds:
  - the FSM state enum;
  - constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_POLY, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hC704DD7B.
- One sub-module, rx_crc32_d8: a byte-wide CRC-32 next-state engine with register, enable and synchronous preset.

Test Plan:
1. Good frame: 7x8'h55, 8'hD5, payload 8'h00..8'h3B (60 bytes), correct FCS -> 60 rx_valid beats, rx_sof on 8'h00, last beat 8'h3B, then rx_eof with rx_good=1, rx_len=64.
2. Same frame with FCS byte 0 bit 0 flipped -> identical data beats; rx_eof with rx_crc_err=1, rx_good=0, rx_len=64.
3. gmii_rx_er=1 on payload byte 10 -> rx_eof with rx_phy_err=1, rx_good=0, rx_crc_err independently evaluated.
4. Runt: 20 payload bytes plus correct FCS -> 20 beats, rx_eof with rx_len=24, rx_len_err=1, rx_crc_err=0; an oversize 1600-byte frame -> rx_len=1600, rx_len_err=1.
5. Preamble 55 55 AA ... -> no rx_valid and no rx_eof; the next clean frame is received correctly.
6. rst_n pulsed low mid-payload -> outputs 0, no eof for that frame; remaining bytes ignored until dv=0; next frame received with rx_good=1. Also send two good frames separated by a single dv=0 cycle -> two rx_eof, both rx_good=1.

Source files
------------

// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII receive path.
// Holds the receive FSM state type, the preamble/SFD byte values and the CRC-32
// constants, plus the byte-wide CRC-32 next-state function used by rx_crc32_d8.
package gmii_pkg;

  typedef enum logic [1:0] {
    StWaitIdle,
    StIdle,
    StPreamble,
    StData
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  // MSB-first shift register; GMII bytes arrive LSB-first on the wire, so the
  // engine input bit i is data[7-i], i.e. data[0] is folded in first.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/rx_crc32_d8.sv
// Byte-wide CRC-32 engine with register.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset (register goes to CRC_INIT)
//   init  - synchronous preset to CRC_INIT (wins over en)
//   en    - fold data into the register this cycle
//   data  - GMII byte as received
//   crc   - current register value
module rx_crc32_d8
  import gmii_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc32_d8(crc_q, data);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/gmii_rx_fcs_check.sv
// GMII receive frame checker.
// Strips preamble/SFD, streams payload with the 4-byte FCS removed (held back in a
// 4-byte delay line), checks the CRC-32 residue and frame length, and emits a
// single-cycle end-of-frame status strobe.
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   gmii_rxd, gmii_rx_dv, gmii_rx_er - registered GMII receive pins
//   rx_data, rx_valid, rx_sof        - payload stream
//   rx_eof                           - frame-end strobe, qualifies the status below
//   rx_good, rx_crc_err, rx_len_err,
//   rx_phy_err, rx_len               - end-of-frame status
// Optional macro RX_STATS_EN adds parameter CNT_W, input stat_clr and saturating
// counters stat_good_cnt, stat_crc_cnt, stat_len_cnt, stat_phy_cnt.
module gmii_rx_fcs_check
  import gmii_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
`ifdef RX_STATS_EN
  ,
  parameter int unsigned CNT_W   = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef RX_STATS_EN
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stat_good_cnt,
  output logic [CNT_W-1:0] stat_crc_cnt,
  output logic [CNT_W-1:0] stat_len_cnt,
  output logic [CNT_W-1:0] stat_phy_cnt,
`endif
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic             rx_good,
  output logic             rx_crc_err,
  output logic             rx_len_err,
  output logic             rx_phy_err,
  output logic [15:0]      rx_len
);

  rx_state_e       state_q, state_d;
  logic            crc_init, crc_en;
  logic [31:0]     crc;
  logic [15:0]     len_q, len_d;
  logic            phy_err_q, phy_err_d;
  logic [3:0][7:0] dly_q, dly_d;  // [0] newest, [3] oldest

  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_sof_q, rx_sof_d;
  logic        rx_eof_q, rx_eof_d;
  logic        rx_good_q, rx_good_d;
  logic        rx_crc_err_q, rx_crc_err_d;
  logic        rx_len_err_q, rx_len_err_d;
  logic        rx_phy_err_q, rx_phy_err_d;
  logic [15:0] rx_len_q, rx_len_d;
  logic        crc_bad, len_bad;

  rx_crc32_d8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .data  (gmii_rxd),
    .crc   (crc)
  );

  assign crc_bad = (crc != CRC_RESIDUE);
  assign len_bad = (32'(len_q) < MIN_LEN) || (32'(len_q) > MAX_LEN);

  always_comb begin
    state_d      = state_q;
    crc_init     = 1'b0;
    crc_en       = 1'b0;
    len_d        = len_q;
    phy_err_d    = phy_err_q;
    dly_d        = dly_q;
    rx_data_d    = 8'h00;
    rx_valid_d   = 1'b0;
    rx_sof_d     = 1'b0;
    rx_eof_d     = 1'b0;
    rx_good_d    = 1'b0;
    rx_crc_err_d = 1'b0;
    rx_len_err_d = 1'b0;
    rx_phy_err_d = 1'b0;
    rx_len_d     = 16'h0000;

    unique case (state_q)
      // Hold off until the line is quiet so a frame already in flight is ignored.
      StWaitIdle: begin
        if (!gmii_rx_dv) state_d = StIdle;
      end
      StIdle: begin
        if (gmii_rx_dv) begin
          state_d = (gmii_rxd == PREAMBLE_BYTE && !gmii_rx_er) ? StPreamble : StWaitIdle;
        end
      end
      StPreamble: begin
        if (!gmii_rx_dv) begin
          state_d = StIdle;
        end else if (gmii_rx_er) begin
          state_d = StWaitIdle;
        end else if (gmii_rxd == PREAMBLE_BYTE) begin
          state_d = StPreamble;
        end else if (gmii_rxd == SFD_BYTE) begin
          state_d   = StData;
          crc_init  = 1'b1;
          len_d     = 16'h0000;
          phy_err_d = 1'b0;
          dly_d     = '0;
        end else begin
          state_d = StWaitIdle;
        end
      end
      StData: begin
        if (gmii_rx_dv) begin
          crc_en = 1'b1;
          if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
          if (gmii_rx_er) phy_err_d = 1'b1;
          dly_d = {dly_q[2:0], gmii_rxd};
          // Once four bytes are buffered, each new byte pushes the oldest one out.
          if (len_q >= 16'd4) begin
            rx_valid_d = 1'b1;
            rx_data_d  = dly_q[3];
            rx_sof_d   = (len_q == 16'd4);
          end
        end else begin
          state_d      = StIdle;
          dly_d        = '0;
          rx_eof_d     = 1'b1;
          rx_len_d     = len_q;
          rx_crc_err_d = crc_bad;
          rx_len_err_d = len_bad;
          rx_phy_err_d = phy_err_q;
          rx_good_d    = !(crc_bad || len_bad || phy_err_q);
        end
      end
      default: state_d = StWaitIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StWaitIdle;
      len_q        <= 16'h0000;
      phy_err_q    <= 1'b0;
      dly_q        <= '0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_sof_q     <= 1'b0;
      rx_eof_q     <= 1'b0;
      rx_good_q    <= 1'b0;
      rx_crc_err_q <= 1'b0;
      rx_len_err_q <= 1'b0;
      rx_phy_err_q <= 1'b0;
      rx_len_q     <= 16'h0000;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      phy_err_q    <= phy_err_d;
      dly_q        <= dly_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_sof_q     <= rx_sof_d;
      rx_eof_q     <= rx_eof_d;
      rx_good_q    <= rx_good_d;
      rx_crc_err_q <= rx_crc_err_d;
      rx_len_err_q <= rx_len_err_d;
      rx_phy_err_q <= rx_phy_err_d;
      rx_len_q     <= rx_len_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_sof     = rx_sof_q;
  assign rx_eof     = rx_eof_q;
  assign rx_good    = rx_good_q;
  assign rx_crc_err = rx_crc_err_q;
  assign rx_len_err = rx_len_err_q;
  assign rx_phy_err = rx_phy_err_q;
  assign rx_len     = rx_len_q;

`ifdef RX_STATS_EN
  logic [CNT_W-1:0] good_cnt_q, crc_cnt_q, len_cnt_q, phy_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      good_cnt_q <= '0;
      crc_cnt_q  <= '0;
      len_cnt_q  <= '0;
      phy_cnt_q  <= '0;
    end else if (rx_eof_q) begin
      if (rx_good_q && !(&good_cnt_q))   good_cnt_q <= good_cnt_q + CNT_W'(1);
      if (rx_crc_err_q && !(&crc_cnt_q)) crc_cnt_q  <= crc_cnt_q + CNT_W'(1);
      if (rx_len_err_q && !(&len_cnt_q)) len_cnt_q  <= len_cnt_q + CNT_W'(1);
      if (rx_phy_err_q && !(&phy_cnt_q)) phy_cnt_q  <= phy_cnt_q + CNT_W'(1);
    end
  end

  assign stat_good_cnt = good_cnt_q;
  assign stat_crc_cnt  = crc_cnt_q;
  assign stat_len_cnt  = len_cnt_q;
  assign stat_phy_cnt  = phy_cnt_q;
`endif

endmodule

// File: tb/tb_gmii_rx_fcs_check.sv
// Directed bench for gmii_rx_fcs_check. Frames are built with a reflected
// (LSB-first) Ethernet CRC-32 model for the FCS; a negedge monitor collects the
// payload stream and end-of-frame status for checking after each frame.
module tb_gmii_rx_fcs_check;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, rx_good, rx_crc_err, rx_len_err, rx_phy_err;
  logic [15:0] rx_len;

  always #5 clk = ~clk;

  gmii_rx_fcs_check #(
    .MIN_LEN (64),
    .MAX_LEN (1518)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gmii_rxd   (gmii_rxd),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rx_er (gmii_rx_er),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_sof     (rx_sof),
    .rx_eof     (rx_eof),
    .rx_good    (rx_good),
    .rx_crc_err (rx_crc_err),
    .rx_len_err (rx_len_err),
    .rx_phy_err (rx_phy_err),
    .rx_len     (rx_len)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] pay   [0:1699];
  logic [7:0] tx    [0:1799];
  logic       tx_er [0:1799];
  int         tx_len;

  // Monitor state
  logic [7:0]  beats[$];
  int          sof_cnt, eof_cnt, good_cnt, viol;
  logic [7:0]  sof_data;
  logic        st_good, st_crc, st_lene, st_phy;
  logic [15:0] st_len;

  always @(negedge clk) begin
    if (rx_valid) beats.push_back(rx_data);
    if (rx_sof) begin
      sof_cnt++;
      sof_data = rx_data;
      if (!rx_valid) viol++;
    end
    if (rx_eof) begin
      eof_cnt++;
      if (rx_good) good_cnt++;
      st_good = rx_good;
      st_crc  = rx_crc_err;
      st_lene = rx_len_err;
      st_phy  = rx_phy_err;
      st_len  = rx_len;
      if (rx_valid) viol++;
    end else if (rx_good || rx_crc_err || rx_len_err || rx_phy_err || rx_len != 16'h0) begin
      viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Clear on posedge so it never races the negedge monitor.
  task automatic clear_mon();
    @(posedge clk);
    beats.delete();
    sof_cnt  = 0;
    eof_cnt  = 0;
    good_cnt = 0;
    viol     = 0;
    sof_data = 8'hXX;
    {st_good, st_crc, st_lene, st_phy} = 4'hX;
    st_len   = 16'hXXXX;
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(negedge clk);
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    gmii_rxd   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  function automatic logic [31:0] eth_fcs(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, pay[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic fill_pay(input int n, input int seed);
    for (int i = 0; i < n; i++) pay[i] = 8'(i + seed);
  endtask

  // Build preamble + SFD + payload + FCS into tx[]; er_idx < 0 means no error.
  task automatic build(input int n, input logic flip, input int er_idx);
    logic [31:0] f;
    f = eth_fcs(n);
    for (int i = 0; i < 7; i++) tx[i] = 8'h55;
    tx[7] = 8'hD5;
    for (int i = 0; i < n; i++) tx[8 + i] = pay[i];
    tx[8 + n]     = f[7:0] ^ {7'b0, flip};
    tx[8 + n + 1] = f[15:8];
    tx[8 + n + 2] = f[23:16];
    tx[8 + n + 3] = f[31:24];
    tx_len = n + 12;
    for (int i = 0; i < tx_len; i++) tx_er[i] = 1'b0;
    if (er_idx >= 0) tx_er[8 + er_idx] = 1'b1;
  endtask

  task automatic send();
    for (int i = 0; i < tx_len; i++) drive(1'b1, tx_er[i], tx[i]);
  endtask

  task automatic check_frame(input string tag, input int n, input logic good, input logic crce,
                             input logic lene, input logic phye, input int len);
    int mism;
    mism = 0;
    for (int i = 0; i < beats.size() && i < n; i++) if (beats[i] !== pay[i]) mism++;
    check({tag, "_beats"}, 32'(beats.size()), 32'(n));
    check({tag, "_data_mism"}, 32'(mism), 32'd0);
    check({tag, "_sof_cnt"}, 32'(sof_cnt), 32'd1);
    check({tag, "_sof_data"}, {24'h0, sof_data}, {24'h0, pay[0]});
    check({tag, "_eof_cnt"}, 32'(eof_cnt), 32'd1);
    check({tag, "_status"}, {28'h0, st_good, st_crc, st_lene, st_phy},
          {28'h0, good, crce, lene, phye});
    check({tag, "_len"}, {16'h0, st_len}, 32'(len));
    check({tag, "_viol"}, 32'(viol), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    gmii_rxd   = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {2'b0, rx_data, rx_valid, rx_sof, rx_eof, rx_good, rx_crc_err,
          rx_len_err, rx_phy_err, rx_len, 1'b0}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // 1. Good minimum frame
    clear_mon();
    fill_pay(60, 0);
    build(60, 1'b0, -1);
    send();
    idle(4);
    check_frame("good64", 60, 1'b1, 1'b0, 1'b0, 1'b0, 64);
    check("good64_last", {24'h0, beats[beats.size() - 1]}, 32'h3B);

    // 2. FCS bit flipped
    clear_mon();
    build(60, 1'b1, -1);
    send();
    idle(4);
    check_frame("crcbad", 60, 1'b0, 1'b1, 1'b0, 1'b0, 64);

    // 3. PHY error on payload byte 10
    clear_mon();
    fill_pay(70, 8'h20);
    build(70, 1'b0, 10);
    send();
    idle(4);
    check_frame("phyerr", 70, 1'b0, 1'b0, 1'b0, 1'b1, 74);

    // 4a. Runt
    clear_mon();
    fill_pay(20, 8'h80);
    build(20, 1'b0, -1);
    send();
    idle(4);
    check_frame("runt", 20, 1'b0, 1'b0, 1'b1, 1'b0, 24);

    // 4b. Oversize
    clear_mon();
    fill_pay(1596, 3);
    build(1596, 1'b0, -1);
    send();
    idle(4);
    check_frame("oversize", 1596, 1'b0, 1'b0, 1'b1, 1'b0, 1600);

    // 5. Bad preamble byte, then a frame-looking tail that must be ignored
    clear_mon();
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 70; i++) drive(1'b1, 1'b0, 8'(i));
    idle(4);
    check("badpre_beats", 32'(beats.size()), 32'd0);
    check("badpre_eof", 32'(eof_cnt), 32'd0);
    clear_mon();
    fill_pay(100, 8'h40);
    build(100, 1'b0, -1);
    send();
    idle(4);
    check_frame("afterbad", 100, 1'b1, 1'b0, 1'b0, 1'b0, 104);

    // 6a. Reset mid-payload
    clear_mon();
    fill_pay(64, 8'h11);
    build(64, 1'b0, -1);
    for (int i = 0; i < 38; i++) drive(1'b1, tx_er[i], tx[i]);
    drive(1'b1, 1'b0, tx[38]);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_outputs", {2'b0, rx_data, rx_valid, rx_sof, rx_eof, rx_good, rx_crc_err,
          rx_len_err, rx_phy_err, rx_len, 1'b0}, 32'h0);
    drive(1'b1, 1'b0, tx[39]);
    clear_mon();
    drive(1'b1, 1'b0, tx[40]);
    rst_n = 1'b1;
    for (int i = 41; i < tx_len; i++) drive(1'b1, 1'b0, tx[i]);
    idle(4);
    check("midrst_beats", 32'(beats.size()), 32'd0);
    check("midrst_eof", 32'(eof_cnt), 32'd0);
    clear_mon();
    send();
    idle(4);
    check_frame("afterrst", 64, 1'b1, 1'b0, 1'b0, 1'b0, 68);

    // 6b. Back-to-back with a single idle cycle
    clear_mon();
    fill_pay(64, 8'h99);
    build(64, 1'b0, -1);
    send();
    idle(1);
    send();
    idle(4);
    check("b2b_eof", 32'(eof_cnt), 32'd2);
    check("b2b_good", 32'(good_cnt), 32'd2);
    check("b2b_beats", 32'(beats.size()), 32'd128);
    check("b2b_sof", 32'(sof_cnt), 32'd2);
    check("b2b_viol", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
